// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol timer and its key synchroniser.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_e;

  localparam int CODE_W = 5;
  localparam int LEN_W  = 3;
  localparam int CNT_W  = 4;

  localparam int DEF_DASH_TICKS   = 2;
  localparam int DEF_LETTER_GAP   = 3;
  localparam int DEF_WORD_GAP     = 7;
  localparam int DEF_MAX_LEN      = 5;
  localparam int LONG_PRESS_TICKS = 8;

  localparam logic SYM_DASH = 1'b1;
  localparam logic SYM_DOT  = 1'b0;

  // Tick counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/morse_key_sync.sv
// Two-flop synchroniser for the raw Morse key, with single-cycle rise/fall
// pulses taken from the synchronised level against its registered copy.
module morse_key_sync (
  input  logic iCLK,
  input  logic iRST,
  input  logic key_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic skey_q;
  logic prev_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      meta_q <= 1'b0;
      skey_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= key_i;
      skey_q <= meta_q;
      prev_q <= skey_q;
    end
  end

  assign rise_o = skey_q & ~prev_q;
  assign fall_o = ~skey_q & prev_q;

endmodule

// File: rtl/morse_symbol_timer.sv
// Times key presses/gaps against the half-second count, builds the letter buffer
// and flags letter/word ends. Optional: MORSE_LONG_PRESS_CLEAR_EN (long press clears).
module morse_symbol_timer
  import morse_pkg::*;
#(
  parameter int DASH_TICKS = DEF_DASH_TICKS,
  parameter int LETTER_GAP = DEF_LETTER_GAP,
  parameter int WORD_GAP   = DEF_WORD_GAP,
  parameter int MAX_LEN    = DEF_MAX_LEN
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [3:0]        iHalfSec,
  input  logic              iKey,
  output logic              oSymValid,
  output logic              oSymDash,
  output logic [CODE_W-1:0] oCode,
  output logic [LEN_W-1:0]  oLen,
  output logic              oLetterEnd,
  output logic              oWordEnd,
  output logic              oOverrun
);

  state_e state_q, state_d;

  logic              key_rise, key_fall;
  logic [3:0]        hs_prev_q;
  logic              tick;
  logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  gap_inc;
  logic [CODE_W-1:0] code_q, code_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              overrun_q, overrun_d;
  logic              sym_valid_q, sym_valid_d;
  logic              sym_dash_q, sym_dash_d;
  logic              letter_end_q, letter_end_d;
  logic              word_end_q, word_end_d;
  logic              gap_step, letter_hit, word_hit, long_press, dash;

  morse_key_sync u_key_sync (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .key_i  (iKey),
    .rise_o (key_rise),
    .fall_o (key_fall)
  );

  assign tick = (iHalfSec != hs_prev_q);

`ifdef MORSE_LONG_PRESS_CLEAR_EN
  assign long_press = (press_cnt_q >= CNT_W'(LONG_PRESS_TICKS));
`else
  assign long_press = 1'b0;
`endif

  // A rise in GAP wins over any gap threshold reached in the same cycle.
  assign gap_inc    = sat_inc(gap_cnt_q);
  assign gap_step   = (state_q == GAP) && !key_rise && tick;
  assign letter_hit = gap_step && (gap_inc != gap_cnt_q) &&
                      (gap_inc == CNT_W'(LETTER_GAP)) && (len_q != '0);
  assign word_hit   = gap_step && (gap_inc != gap_cnt_q) &&
                      (gap_inc == CNT_W'(WORD_GAP));
  assign dash       = (press_cnt_q >= CNT_W'(DASH_TICKS)) ? SYM_DASH : SYM_DOT;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_rise) state_d = PRESS;
      PRESS:   if (key_fall) state_d = long_press ? IDLE : GAP;
      GAP: begin
        if (key_rise)      state_d = PRESS;
        else if (word_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    press_cnt_d  = press_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    code_d       = code_q;
    len_d        = len_q;
    overrun_d    = overrun_q;
    sym_valid_d  = 1'b0;
    sym_dash_d   = 1'b0;
    letter_end_d = letter_hit;
    word_end_d   = word_hit;
    // The completed letter is visible during the oLetterEnd cycle, then dropped.
    if (letter_end_q) begin
      code_d    = '0;
      len_d     = '0;
      overrun_d = 1'b0;
    end
    case (state_q)
      IDLE: if (key_rise) press_cnt_d = '0;
      PRESS: begin
        if (key_fall) begin
          gap_cnt_d = '0;
          if (long_press) begin
            code_d    = '0;
            len_d     = '0;
            overrun_d = 1'b0;
          end else begin
            sym_valid_d = 1'b1;
            sym_dash_d  = dash;
            if (len_q < LEN_W'(MAX_LEN)) begin
              code_d = {code_q[CODE_W-2:0], dash};
              len_d  = len_q + 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else if (tick) begin
          press_cnt_d = sat_inc(press_cnt_q);
        end
      end
      GAP: begin
        if (key_rise)  press_cnt_d = '0;
        else if (tick) gap_cnt_d   = gap_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hs_prev_q    <= '0;
      press_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      code_q       <= '0;
      len_q        <= '0;
      overrun_q    <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_dash_q   <= 1'b0;
      letter_end_q <= 1'b0;
      word_end_q   <= 1'b0;
    end else begin
      hs_prev_q    <= iHalfSec;
      press_cnt_q  <= press_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      code_q       <= code_d;
      len_q        <= len_d;
      overrun_q    <= overrun_d;
      sym_valid_q  <= sym_valid_d;
      sym_dash_q   <= sym_dash_d;
      letter_end_q <= letter_end_d;
      word_end_q   <= word_end_d;
    end
  end

  assign oSymValid  = sym_valid_q;
  assign oSymDash   = sym_dash_q;
  assign oCode      = code_q;
  assign oLen       = len_q;
  assign oLetterEnd = letter_end_q;
  assign oWordEnd   = word_end_q;
  assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Directed bench for morse_symbol_timer: expected symbol/letter/word events are
// queued as stimulus is driven and checked as the pulses appear.
module tb_morse_symbol_timer;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic [3:0] iHalfSec;
  logic       iKey;
  logic       oSymValid, oSymDash, oLetterEnd, oWordEnd, oOverrun;
  logic [4:0] oCode;
  logic [2:0] oLen;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int         kind;  // 0 symbol, 1 letter end, 2 word end
    logic       dash;
    logic [4:0] code;
    logic [2:0] len;
    logic       ovr;
  } ev_t;
  ev_t exp_q[$];

  always #10 iCLK = ~iCLK;

  morse_symbol_timer dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iHalfSec   (iHalfSec),
    .iKey       (iKey),
    .oSymValid  (oSymValid),
    .oSymDash   (oSymDash),
    .oCode      (oCode),
    .oLen       (oLen),
    .oLetterEnd (oLetterEnd),
    .oWordEnd   (oWordEnd),
    .oOverrun   (oOverrun)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int kind, input logic dash, input logic [4:0] code,
                      input logic [2:0] len, input logic ovr);
    ev_t e;
    e.kind = kind; e.dash = dash; e.code = code; e.len = len; e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_pulse", 8'(kind), 8'hFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 8'(kind), 8'(e.kind));
      if (kind == 0) begin
        check("sym_dash", {7'd0, oSymDash}, {7'd0, e.dash});
        check("sym_code", {3'd0, oCode}, {3'd0, e.code});
        check("sym_len", {5'd0, oLen}, {5'd0, e.len});
        check("sym_overrun", {7'd0, oOverrun}, {7'd0, e.ovr});
      end else if (kind == 1) begin
        check("letter_code", {3'd0, oCode}, {3'd0, e.code});
        check("letter_len", {5'd0, oLen}, {5'd0, e.len});
      end
    end
  endtask

  // One clock; outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge iCLK);
    if (oSymValid)  pop_check(0);
    if (oLetterEnd) pop_check(1);
    if (oWordEnd)   pop_check(2);
  endtask

  task automatic tick();
    iHalfSec = iHalfSec + 4'd1;
    repeat (4) cyc();
  endtask

  task automatic press(input int n);
    iKey = 1'b1;
    repeat (4) cyc();
    repeat (n) tick();
    iKey = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic drained(input string tag);
    check(tag, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    iRST = 1'b1; iKey = 1'b0; iHalfSec = 4'd0;
    repeat (3) cyc();
    check("rst_symvalid", {7'd0, oSymValid}, 8'd0);
    check("rst_code", {3'd0, oCode}, 8'd0);
    check("rst_len", {5'd0, oLen}, 8'd0);
    check("rst_ends", {6'd0, oLetterEnd, oWordEnd}, 8'd0);
    iRST = 1'b0;
    repeat (3) cyc();

    // 'E': one dot, then letter end at 3 idle ticks and word end at 7.
    push(0, 1'b0, 5'b00000, 3'd1, 1'b0);
    press(1);
    push(1, 1'b0, 5'b00000, 3'd1, 1'b0);
    gap(3);
    check("e_len_cleared", {5'd0, oLen}, 8'd0);
    push(2, 1'b0, 5'b0, 3'd0, 1'b0);
    gap(4);
    drained("e_drained");

    // 'A': dot, 1-tick gap, 3-tick dash.
    push(0, 1'b0, 5'b00000, 3'd1, 1'b0);
    press(1);
    gap(1);
    push(0, 1'b1, 5'b00001, 3'd2, 1'b0);
    press(3);
    push(1, 1'b0, 5'b00001, 3'd2, 1'b0);
    gap(3);
    check("a_len_cleared", {5'd0, oLen}, 8'd0);
    push(2, 1'b0, 5'b0, 3'd0, 1'b0);
    gap(4);
    drained("a_drained");

    // Six dots: the sixth is dropped and raises the sticky overrun.
    for (int i = 1; i <= 6; i++) begin
      push(0, 1'b0, 5'b00000, (i > 5) ? 3'd5 : 3'(i), (i > 5));
      press(1);
      if (i < 6) gap(1);
    end
    check("ovr_sticky", {7'd0, oOverrun}, 8'd1);
    push(1, 1'b0, 5'b00000, 3'd5, 1'b0);
    gap(3);
    check("ovr_cleared", {7'd0, oOverrun}, 8'd0);
    check("ovr_len_cleared", {5'd0, oLen}, 8'd0);
    push(2, 1'b0, 5'b0, 3'd0, 1'b0);
    gap(4);
    drained("ovr_drained");

    // Press spanning 14->15->0: the wrap is a tick, so two ticks make a dash.
    iHalfSec = 4'd14;
    repeat (4) cyc();
    push(0, 1'b1, 5'b00001, 3'd1, 1'b0);
    press(2);
    push(1, 1'b0, 5'b00001, 3'd1, 1'b0);
    gap(3);
    push(2, 1'b0, 5'b0, 3'd0, 1'b0);
    gap(4);
    drained("wrap_drained");

    // Reset in the middle of a press discards the letter and issues no pulses.
    push(0, 1'b0, 5'b00000, 3'd1, 1'b0);
    press(1);
    gap(1);
    iKey = 1'b1;
    repeat (4) cyc();
    tick();
    iRST = 1'b1;
    #1;
    check("midrst_outputs", {oSymValid, oSymDash, oLetterEnd, oWordEnd, oOverrun, oLen},
          8'd0);
    check("midrst_code", {3'd0, oCode}, 8'd0);
    iKey = 1'b0;
    repeat (4) cyc();
    iRST = 1'b0;
    gap(8);
    check("midrst_len", {5'd0, oLen}, 8'd0);
    drained("midrst_drained");

    // Two dots then a 9-tick hold.
    push(0, 1'b0, 5'b00000, 3'd1, 1'b0);
    press(1);
    gap(1);
    push(0, 1'b0, 5'b00000, 3'd2, 1'b0);
    press(1);
    gap(1);
`ifdef MORSE_LONG_PRESS_CLEAR_EN
    press(9);
    check("long_len", {5'd0, oLen}, 8'd0);
    gap(8);
`else
    push(0, 1'b1, 5'b00001, 3'd3, 1'b0);
    press(9);
    check("long_len", {5'd0, oLen}, 8'd3);
    push(1, 1'b0, 5'b00001, 3'd3, 1'b0);
    gap(3);
    push(2, 1'b0, 5'b0, 3'd0, 1'b0);
    gap(4);
`endif
    repeat (4) cyc();
    drained("final_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
